axi_dma_mc_sched: RTL and testbench
===================================

# axi_dma_mc_sched

Multi-channel burst scheduler for the next-generation AXI4 DMA subsystem. It accepts per-channel transfer requests (source address, destination address, byte length) and splits each into AXI-legal bursts. Bursts are capped at MAX_BURST beats and never cross a 4 KB boundary on either address. Bursts are issued round-robin across channels to a single read/write datapath. The block tracks outstanding bursts per channel, signals per-channel completion and raises a maskable pending interrupt; it sits between the register block and the AXI master engine.

## Interface
- NUM_CH, 4: number of independent DMA channels (1–16)
- AXI_ADDR_W, 32: address width
- AXI_DATA_W, 128: datapath width; beat size BB = AXI_DATA_W/8 bytes
- LEN_W, 24: request byte-length width
- MAX_BURST, 16: max beats per burst (1–256)
- MAX_OUT, 8: max outstanding bursts per channel
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous active-low
- ch_req_valid  in  NUM_CH  per-channel request valid
- ch_req_ready  out  NUM_CH  per-channel request ready
- ch_req_src  in  NUM_CH×AXI_ADDR_W  source byte address
- ch_req_dst  in  NUM_CH×AXI_ADDR_W  destination byte address
- ch_req_len  in  NUM_CH×LEN_W  transfer length in bytes
- cmd_valid / cmd_ready  out / in  1  burst command handshake
- cmd_ch  out  clog2(NUM_CH)  owning channel
- cmd_src, cmd_dst  out  AXI_ADDR_W  burst start addresses
- cmd_len  out  8  beats−1 (AXI arlen/awlen encoding)
- cmd_last  out  1  final burst of the request
- cpl_valid  in  1  burst completion (write response received)
- cpl_ch  in  clog2(NUM_CH)  completing channel
- cpl_err  in  1  burst returned SLVERR/DECERR
- ch_busy  out  NUM_CH  channel not IDLE
- ch_done  out  NUM_CH  one-cycle completion pulse
- ch_err  out  NUM_CH  sticky error, cleared on next request accept
- intr_en  in  NUM_CH  interrupt enable mask
- intr_clr  in  NUM_CH  write-1-to-clear for interrupt status
- intr_pend  out  1  OR of (intr_stat & intr_en)
- proto_err  out  1  sticky; completion received with zero outstanding

## Operation
- Per-channel FSM: IDLE → ISSUE → DRAIN → IDLE.
- IDLE: ch_req_ready=1. On handshake, latch src/dst, set beats_rem = len/BB, clear ch_err.
  - Low log2(BB) bits of addresses and length are ignored (treated as 0).
  - If beats_rem == 0, go to DRAIN; otherwise go to ISSUE.
- ISSUE: the channel is eligible when outstanding < MAX_OUT.
  - Burst beats = min(beats_rem, MAX_BURST, beats to next 4 KB boundary of src, beats to next 4 KB boundary of dst).
  - On command handshake: src += beats×BB, dst += beats×BB, beats_rem −= beats, outstanding += 1.
  - When beats_rem reaches 0, cmd_last=1 on that command and the FSM goes to DRAIN.
- DRAIN: when outstanding == 0, pulse ch_done, set intr_stat, go to IDLE.
- Completion: cpl_valid decrements outstanding[cpl_ch] and ORs cpl_err into ch_err.
  - Completion and issue on the same channel in the same cycle leave outstanding unchanged.
  - Completion to a channel with outstanding == 0 is ignored and sets proto_err.
- Arbiter: round-robin over eligible channels, starting after the last granted channel. The pointer advances only on a cmd handshake.
- Command stage: a single registered entry.
  - Loaded when the entry is empty, or in the same cycle its handshake completes.
  - Held stable while cmd_valid && !cmd_ready.
- Interrupt: intr_stat[i] is set on ch_done[i] and cleared by intr_clr[i]; if both occur in the same cycle, set wins.

## Timing
- Reset values: all outputs 0 except ch_req_ready = all ones. All FSMs IDLE, counters 0, arbiter pointer 0.
- Reset mid-operation clears everything immediately (asynchronous); no partial completions are reported.
- Request handshake at cycle T:
  - ch_busy is high from T+1.
  - The first cmd_valid is high at T+2 if the command stage is free.
- Back-to-back commands: one per cycle while cmd_ready=1 and a channel is eligible.
- Last completion seen at cycle C: ch_done pulses at C+1, intr_pend is high at C+2, ch_req_ready returns high at C+2.
- Zero-length request at T: ch_done pulses at T+1.
- Burst length arithmetic is done in 13-bit beats-to-boundary math; cmd_len never exceeds MAX_BURST−1 or 255.

## Test plan
- Single-channel bulk transfer: BB=16, MAX_BURST=16; ch0 src=0x1000, dst=0x8000, len=4096.
  - Expect 16 commands, each cmd_len=15; src steps by 0x100; cmd_last only on the 16th.
  - After 16 completions, ch_done[0] pulses once.
- 4 KB split: ch1 src=0x0FC0, dst=0x20000, len=256.
  - Expect command 1: cmd_len=3 at 0x0FC0.
  - Expect command 2: cmd_len=11 at 0x1000, with cmd_last=1.
- Round-robin and backpressure:
  - ch0 and ch2 each request 1024 bytes simultaneously; expect cmd_ch to alternate 0, 2, 0, 2.
  - Hold cmd_ready low for 5 cycles; all cmd_* must stay stable.
- Outstanding cap and errors, MAX_OUT=2, no completions:
  - ch3 issues exactly 2 commands, then stalls.
  - A completion with cpl_err=1 resumes issue; ch_err[3] is high at done.
- Zero length and protocol error:
  - len=0 → ch_done at T+1, no command issued.
  - cpl_valid to an idle channel → proto_err=1, no counter underflow.
- Interrupt and reset:
  - intr_clr coincident with ch_done → intr_stat stays 1.
  - rst_n asserted mid-burst → all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/axi_dma_mc_sched_if.sv
// Bus bundle between the register block / AXI master engine and the burst scheduler:
// per-channel requests, the burst command stage and burst completions.
interface axi_dma_mc_sched_if #(
  parameter int NUM_CH     = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int LEN_W      = 24,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]            ch_req_valid;
  logic [NUM_CH-1:0]            ch_req_ready;
  logic [NUM_CH*AXI_ADDR_W-1:0] ch_req_src;
  logic [NUM_CH*AXI_ADDR_W-1:0] ch_req_dst;
  logic [NUM_CH*LEN_W-1:0]      ch_req_len;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CH_W-1:0]       cmd_ch;
  logic [AXI_ADDR_W-1:0] cmd_src;
  logic [AXI_ADDR_W-1:0] cmd_dst;
  logic [7:0]            cmd_len;
  logic                  cmd_last;

  logic                  cpl_valid;
  logic [CH_W-1:0]       cpl_ch;
  logic                  cpl_err;

  modport master (
    input  ch_req_valid, ch_req_src, ch_req_dst, ch_req_len,
    input  cmd_ready, cpl_valid, cpl_ch, cpl_err,
    output ch_req_ready, cmd_valid, cmd_ch, cmd_src, cmd_dst, cmd_len, cmd_last
  );

  modport slave (
    output ch_req_valid, ch_req_src, ch_req_dst, ch_req_len,
    output cmd_ready, cpl_valid, cpl_ch, cpl_err,
    input  ch_req_ready, cmd_valid, cmd_ch, cmd_src, cmd_dst, cmd_len, cmd_last
  );
endinterface

// File: rtl/axi_dma_mc_sched.sv
// Multi-channel DMA burst scheduler: splits requests into 4 KB-safe bursts capped at
// MAX_BURST beats, arbitrates channels round-robin and tracks outstanding bursts.
module axi_dma_mc_sched #(
  parameter int NUM_CH     = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 128,
  parameter int LEN_W      = 24,
  parameter int MAX_BURST  = 16,
  parameter int MAX_OUT    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi_dma_mc_sched_if.master     bus,
  output logic [NUM_CH-1:0]      ch_busy,
  output logic [NUM_CH-1:0]      ch_done,
  output logic [NUM_CH-1:0]      ch_err,
  input  logic [NUM_CH-1:0]      intr_en,
  input  logic [NUM_CH-1:0]      intr_clr,
  output logic                   intr_pend,
  output logic                   proto_err
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BB    = AXI_DATA_W / 8;
  localparam int OFS_W = $clog2(BB);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int BCAP  = (MAX_BURST > 256) ? 256 : MAX_BURST;
  localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = ~AXI_ADDR_W'(BB - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DRAIN = 2'd2} st_e;

  st_e                   state_q [NUM_CH];
  st_e                   state_d [NUM_CH];
  logic [AXI_ADDR_W-1:0] src_q [NUM_CH];
  logic [AXI_ADDR_W-1:0] src_d [NUM_CH];
  logic [AXI_ADDR_W-1:0] dst_q [NUM_CH];
  logic [AXI_ADDR_W-1:0] dst_d [NUM_CH];
  logic [LEN_W-1:0]      rem_q [NUM_CH];
  logic [LEN_W-1:0]      rem_d [NUM_CH];
  logic [OUT_W-1:0]      out_q [NUM_CH];
  logic [OUT_W-1:0]      out_d [NUM_CH];
  logic [NUM_CH-1:0]     err_q, err_d, done_q, done_d, stat_q, stat_d;
  logic                  intr_pend_q, intr_pend_d, proto_err_q, proto_err_d;
  logic [CH_W-1:0]       ptr_q, ptr_d;

  logic                  cmd_valid_q, cmd_valid_d, cmd_last_q, cmd_last_d;
  logic [CH_W-1:0]       cmd_ch_q, cmd_ch_d;
  logic [AXI_ADDR_W-1:0] cmd_src_q, cmd_src_d, cmd_dst_q, cmd_dst_d;
  logic [7:0]            cmd_len_q, cmd_len_d;

  logic [LEN_W-1:0]      req_beats_s [NUM_CH];
  logic [8:0]            beats_s [NUM_CH];
  logic [NUM_CH-1:0]     elig_s, acc_s, iss_s, cpl_hit_s, dec_s, ready_s;
  logic                  gnt_valid_s, load_s, hit_s;
  logic [CH_W-1:0]       gnt_ch_s, idx_s;

  // Burst size: smallest of remaining beats, burst cap and beats left before either 4 KB page ends.
  function automatic logic [8:0] burst_beats(input logic [11:0] s, input logic [11:0] d,
                                             input logic [LEN_W-1:0] r);
    logic [12:0] sb, db, c;
    sb = (13'h1000 - {1'b0, s}) >> OFS_W;
    db = (13'h1000 - {1'b0, d}) >> OFS_W;
    c  = 13'(BCAP);
    c  = (sb < c) ? sb : c;
    c  = (db < c) ? db : c;
    c  = (r < LEN_W'(c)) ? 13'(r) : c;
    return 9'(c);
  endfunction

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return CH_W'((s >= NUM_CH) ? (s - NUM_CH) : s);
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign req_beats_s[i] = bus.ch_req_len[i*LEN_W +: LEN_W] >> OFS_W;
    assign beats_s[i]     = burst_beats(src_q[i][11:0], dst_q[i][11:0], rem_q[i]);
    assign elig_s[i]      = (state_q[i] == ST_ISSUE) && (out_q[i] < OUT_W'(MAX_OUT));
    assign acc_s[i]       = (state_q[i] == ST_IDLE) && bus.ch_req_valid[i];
    assign iss_s[i]       = load_s && (gnt_ch_s == CH_W'(i));
    assign cpl_hit_s[i]   = bus.cpl_valid && (bus.cpl_ch == CH_W'(i));
    assign dec_s[i]       = cpl_hit_s[i] && (out_q[i] != {OUT_W{1'b0}});
    assign ready_s[i]     = (state_q[i] == ST_IDLE);
    assign ch_busy[i]     = (state_q[i] != ST_IDLE);
  end

  // Round-robin search begins one past the most recently granted channel.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_ch_s    = ptr_q;
    idx_s       = ptr_q;
    hit_s       = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx_s       = rr_idx(ptr_q, k);
      hit_s       = !gnt_valid_s && elig_s[idx_s];
      gnt_ch_s    = hit_s ? idx_s : gnt_ch_s;
      gnt_valid_s = gnt_valid_s | hit_s;
    end
    load_s = gnt_valid_s && (!cmd_valid_q || bus.cmd_ready);
  end

  // Channel state is advanced when a burst is granted into the command stage, so a
  // same-cycle reload for the same channel already sees the updated addresses.
  always_comb begin
    ptr_d       = load_s ? gnt_ch_s : ptr_q;
    proto_err_d = proto_err_q | (bus.cpl_valid && ((cpl_hit_s & ~dec_s) != {NUM_CH{1'b0}}));
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      src_d[i]   = src_q[i];
      dst_d[i]   = dst_q[i];
      rem_d[i]   = rem_q[i];
      done_d[i]  = 1'b0;
      out_d[i]   = out_q[i] + OUT_W'(iss_s[i]) - OUT_W'(dec_s[i]);
      err_d[i]   = err_q[i] | (dec_s[i] & bus.cpl_err);
      case (state_q[i])
        ST_IDLE: begin
          if (acc_s[i]) begin
            src_d[i] = bus.ch_req_src[i*AXI_ADDR_W +: AXI_ADDR_W] & ADDR_MASK;
            dst_d[i] = bus.ch_req_dst[i*AXI_ADDR_W +: AXI_ADDR_W] & ADDR_MASK;
            rem_d[i] = req_beats_s[i];
            err_d[i] = 1'b0;
            if (req_beats_s[i] == {LEN_W{1'b0}}) begin
              state_d[i] = ST_DRAIN;
              done_d[i]  = 1'b1;
            end else begin
              state_d[i] = ST_ISSUE;
            end
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (iss_s[i]) begin
            src_d[i]   = src_q[i] + (AXI_ADDR_W'(beats_s[i]) << OFS_W);
            dst_d[i]   = dst_q[i] + (AXI_ADDR_W'(beats_s[i]) << OFS_W);
            rem_d[i]   = rem_q[i] - LEN_W'(beats_s[i]);
            state_d[i] = (rem_q[i] == LEN_W'(beats_s[i])) ? ST_DRAIN : ST_ISSUE;
          end else begin
            state_d[i] = ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (done_q[i]) begin
            state_d[i] = ST_IDLE;
          end else if (out_d[i] == {OUT_W{1'b0}}) begin
            done_d[i]  = 1'b1;
          end else begin
            state_d[i] = ST_DRAIN;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
      stat_d[i] = (stat_q[i] & ~intr_clr[i]) | done_q[i];
    end
    intr_pend_d = |(stat_d & intr_en);
  end

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_ch_d    = cmd_ch_q;
    cmd_src_d   = cmd_src_q;
    cmd_dst_d   = cmd_dst_q;
    cmd_len_d   = cmd_len_q;
    cmd_last_d  = cmd_last_q;
    if (load_s) begin
      cmd_valid_d = 1'b1;
      cmd_ch_d    = gnt_ch_s;
      cmd_src_d   = src_q[gnt_ch_s];
      cmd_dst_d   = dst_q[gnt_ch_s];
      cmd_len_d   = 8'(beats_s[gnt_ch_s] - 9'd1);
      cmd_last_d  = (rem_q[gnt_ch_s] == LEN_W'(beats_s[gnt_ch_s]));
    end else if (bus.cmd_ready) begin
      cmd_valid_d = 1'b0;
    end else begin
      cmd_valid_d = cmd_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        src_q[i]   <= {AXI_ADDR_W{1'b0}};
        dst_q[i]   <= {AXI_ADDR_W{1'b0}};
        rem_q[i]   <= {LEN_W{1'b0}};
        out_q[i]   <= {OUT_W{1'b0}};
      end
      err_q       <= {NUM_CH{1'b0}};
      done_q      <= {NUM_CH{1'b0}};
      stat_q      <= {NUM_CH{1'b0}};
      intr_pend_q <= 1'b0;
      proto_err_q <= 1'b0;
      ptr_q       <= {CH_W{1'b0}};
      cmd_valid_q <= 1'b0;
      cmd_ch_q    <= {CH_W{1'b0}};
      cmd_src_q   <= {AXI_ADDR_W{1'b0}};
      cmd_dst_q   <= {AXI_ADDR_W{1'b0}};
      cmd_len_q   <= 8'd0;
      cmd_last_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        src_q[i]   <= src_d[i];
        dst_q[i]   <= dst_d[i];
        rem_q[i]   <= rem_d[i];
        out_q[i]   <= out_d[i];
      end
      err_q       <= err_d;
      done_q      <= done_d;
      stat_q      <= stat_d;
      intr_pend_q <= intr_pend_d;
      proto_err_q <= proto_err_d;
      ptr_q       <= ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_ch_q    <= cmd_ch_d;
      cmd_src_q   <= cmd_src_d;
      cmd_dst_q   <= cmd_dst_d;
      cmd_len_q   <= cmd_len_d;
      cmd_last_q  <= cmd_last_d;
    end
  end

  assign bus.ch_req_ready = ready_s;
  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.cmd_ch       = cmd_ch_q;
  assign bus.cmd_src      = cmd_src_q;
  assign bus.cmd_dst      = cmd_dst_q;
  assign bus.cmd_len      = cmd_len_q;
  assign bus.cmd_last     = cmd_last_q;
  assign ch_done          = done_q;
  assign ch_err           = err_q;
  assign intr_pend        = intr_pend_q;
  assign proto_err        = proto_err_q;
endmodule

// File: tb/tb_axi_dma_mc_sched.sv
// Directed bench for axi_dma_mc_sched: expected bursts are queued as stimulus is issued
// and a forked monitor pops and compares them on every command handshake.
module tb_axi_dma_mc_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] ch_busy, ch_done, ch_err, intr_en, intr_clr;
  logic intr_pend, proto_err;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  len;
    logic        last;
  } cmd_t;

  cmd_t       exq [$];
  logic [1:0] cplq [$];
  int total = 0;
  int bad = 0;
  int hs_cnt [4] = '{0, 0, 0, 0};
  int done_cnt [4] = '{0, 0, 0, 0};
  bit auto_cpl = 1'b0;
  bit err_once = 1'b0;
  int d0, h0;

  axi_dma_mc_sched_if #(.NUM_CH(4), .AXI_ADDR_W(32), .LEN_W(24)) bus ();

  axi_dma_mc_sched #(
    .NUM_CH(4), .AXI_ADDR_W(32), .AXI_DATA_W(128), .LEN_W(24), .MAX_BURST(16), .MAX_OUT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err),
    .intr_en(intr_en), .intr_clr(intr_clr), .intr_pend(intr_pend), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [1:0] ch, input logic [31:0] s, input logic [31:0] d,
                              input logic [7:0] l, input logic last);
    cmd_t c;
    c.ch = ch; c.src = s; c.dst = d; c.len = l; c.last = last;
    return c;
  endfunction

  task automatic monitor();
    cmd_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (ch_done[i]) done_cnt[i]++;
      if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
        hs_cnt[bus.cmd_ch]++;
        cplq.push_back(bus.cmd_ch);
        if (exq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd: got ch=%0d src=%0h, none expected", bus.cmd_ch, bus.cmd_src);
        end else begin
          e = exq.pop_front();
          chk("cmd", 128'({bus.cmd_ch, bus.cmd_src, bus.cmd_dst, bus.cmd_len, bus.cmd_last}), 128'(e));
        end
      end
    end
  endtask

  // One clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus.cpl_valid = 1'b0;
    bus.cpl_err   = 1'b0;
    if (auto_cpl && cplq.size() > 0) begin
      bus.cpl_valid = 1'b1;
      bus.cpl_ch    = cplq.pop_front();
      bus.cpl_err   = err_once;
      err_once      = 1'b0;
    end
  endtask

  task automatic do_cpl(input logic [1:0] ch, input logic err);
    step();
    bus.cpl_valid = 1'b1;
    bus.cpl_ch    = ch;
    bus.cpl_err   = err;
  endtask

  task automatic set_req(input int ch, input logic [31:0] s, input logic [31:0] d, input logic [23:0] l);
    bus.ch_req_valid[ch]        = 1'b1;
    bus.ch_req_src[ch*32 +: 32] = s;
    bus.ch_req_dst[ch*32 +: 32] = d;
    bus.ch_req_len[ch*24 +: 24] = l;
  endtask

  task automatic fire();
    step();
    bus.ch_req_valid = 4'h0;
  endtask

  task automatic wait_done(input logic [1:0] ch, input int budget, input string nm);
    int n = 0;
    while (!ch_done[ch] && n < budget) begin
      step();
      n++;
    end
    chk(nm, 128'(ch_done[ch]), 128'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    intr_en = 4'hF;
    intr_clr = 4'h0;
    bus.ch_req_valid = 4'h0;
    bus.ch_req_src = '0;
    bus.ch_req_dst = '0;
    bus.ch_req_len = '0;
    bus.cmd_ready = 1'b1;
    bus.cpl_valid = 1'b0;
    bus.cpl_ch = 2'd0;
    bus.cpl_err = 1'b0;
    fork
      monitor();
    join_none
    step();
    step();
    chk("reset_outputs", 128'({bus.ch_req_ready, ch_busy, ch_done, ch_err, intr_pend, proto_err, bus.cmd_valid}),
        128'({4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0}));
    rst_n = 1'b1;
    step();

    // Zero-length request; intr_clr lands in the same cycle as ch_done
    set_req(1, 32'h100, 32'h200, 24'd0);
    fire();
    chk("zl_done_t1", 128'(ch_done[1]), 128'd1);
    chk("zl_busy_t1", 128'(ch_busy[1]), 128'd1);
    intr_clr = 4'b0010;
    step();
    intr_clr = 4'h0;
    chk("intr_set_wins", 128'(intr_pend), 128'd1);
    chk("zl_done_t2", 128'(ch_done[1]), 128'd0);
    chk("zl_ready_t2", 128'(bus.ch_req_ready[1]), 128'd1);
    intr_clr = 4'b0010;
    step();
    intr_clr = 4'h0;
    chk("intr_cleared", 128'(intr_pend), 128'd0);

    // Outstanding cap of 2 on ch3, then an error completion releases it
    auto_cpl = 1'b0;
    for (int k = 0; k < 4; k++)
      exq.push_back(mk(2'd3, 32'h30000 + 32'(k) * 32'h100, 32'h38000 + 32'(k) * 32'h100, 8'd15, k == 3));
    set_req(3, 32'h30000, 32'h38000, 24'd1024);
    fire();
    repeat (10) step();
    chk("cap_cmds", 128'(hs_cnt[3]), 128'd2);
    chk("cap_stalled", 128'(bus.cmd_valid), 128'd0);
    err_once = 1'b1;
    auto_cpl = 1'b1;
    wait_done(2'd3, 100, "cap_done");
    chk("err_at_done", 128'(ch_err[3]), 128'd1);

    // Round-robin ch0/ch2 and first-command latency
    for (int k = 0; k < 4; k++) begin
      exq.push_back(mk(2'd0, 32'h0 + 32'(k) * 32'h100, 32'h4000 + 32'(k) * 32'h100, 8'd15, k == 3));
      exq.push_back(mk(2'd2, 32'h10000 + 32'(k) * 32'h100, 32'h14000 + 32'(k) * 32'h100, 8'd15, k == 3));
    end
    set_req(0, 32'h0, 32'h4000, 24'd1024);
    set_req(2, 32'h10000, 32'h14000, 24'd1024);
    fire();
    chk("t1_no_valid", 128'(bus.cmd_valid), 128'd0);
    step();
    chk("t2_valid_ch0", 128'({bus.cmd_valid, bus.cmd_ch}), 128'({1'b1, 2'd0}));
    wait_done(2'd2, 200, "rr_done");

    // 4 KB split on ch1 with cmd_ready held low for 5 cycles
    bus.cmd_ready = 1'b0;
    exq.push_back(mk(2'd1, 32'h0FC0, 32'h20000, 8'd3, 1'b0));
    exq.push_back(mk(2'd1, 32'h1000, 32'h20040, 8'd11, 1'b1));
    set_req(1, 32'h0FC0, 32'h20000, 24'd256);
    fire();
    step();
    for (int k = 0; k < 5; k++) begin
      chk("hold_stable", 128'({bus.cmd_valid, bus.cmd_ch, bus.cmd_src, bus.cmd_dst, bus.cmd_len, bus.cmd_last}),
          128'({1'b1, 2'd1, 32'h0FC0, 32'h20000, 8'd3, 1'b0}));
      step();
    end
    bus.cmd_ready = 1'b1;
    wait_done(2'd1, 100, "split_done");

    // Bulk 4096-byte transfer on ch0
    d0 = done_cnt[0];
    h0 = hs_cnt[0];
    for (int k = 0; k < 16; k++)
      exq.push_back(mk(2'd0, 32'h1000 + 32'(k) * 32'h100, 32'h8000 + 32'(k) * 32'h100, 8'd15, k == 15));
    set_req(0, 32'h1000, 32'h8000, 24'd4096);
    fire();
    wait_done(2'd0, 400, "bulk_done");
    repeat (3) step();
    chk("bulk_one_done", 128'(done_cnt[0] - d0), 128'd1);
    chk("bulk_16_cmds", 128'(hs_cnt[0] - h0), 128'd16);

    // Completion to an idle channel, then completion-to-done timing on ch1
    intr_clr = 4'hF;
    step();
    intr_clr = 4'h0;
    auto_cpl = 1'b0;
    cplq.delete();
    do_cpl(2'd1, 1'b0);
    step();
    chk("proto_err", 128'(proto_err), 128'd1);
    exq.push_back(mk(2'd1, 32'h500, 32'h600, 8'd0, 1'b1));
    set_req(1, 32'h50F, 32'h600, 24'd16);
    fire();
    step();
    step();
    cplq.delete();
    do_cpl(2'd1, 1'b0);
    step();
    chk("c1_done", 128'({ch_done[1], bus.ch_req_ready[1]}), 128'({1'b1, 1'b0}));
    step();
    chk("c2_ready_pend", 128'({bus.ch_req_ready[1], intr_pend, ch_done[1]}), 128'({1'b1, 1'b1, 1'b0}));
    chk("exq_drained", 128'(exq.size()), 128'd0);

    // Asynchronous reset in the middle of a bulk transfer
    auto_cpl = 1'b1;
    for (int k = 0; k < 16; k++)
      exq.push_back(mk(2'd0, 32'h2000 + 32'(k) * 32'h100, 32'h9000 + 32'(k) * 32'h100, 8'd15, k == 15));
    set_req(0, 32'h2000, 32'h9000, 24'd4096);
    fire();
    repeat (3) step();
    chk("pre_rst_busy", 128'(ch_busy[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset", 128'({bus.ch_req_ready, ch_busy, ch_done, ch_err, intr_pend, proto_err, bus.cmd_valid}),
        128'({4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0}));
    exq.delete();
    cplq.delete();
    auto_cpl = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_reset_idle", 128'({bus.ch_req_ready, ch_busy, bus.cmd_valid}), 128'({4'hF, 4'h0, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
